// File: rtl/sort_nxw_oet_pipe.sv
// rtl/sort_nxw_oet_pipe.sv - pipelined N-element odd-even transposition sorter; SORT_NXW_INDEX_EN adds out_index
module sort_nxw_oet_pipe #(
    parameter int N         = 8,
    parameter int W         = 8,
    parameter int REG_EVERY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_desc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           out_desc
`ifdef SORT_NXW_INDEX_EN
    ,
    output logic [N*$clog2(N)-1:0] out_index
`endif
);

    localparam int L = (N + REG_EVERY - 1) / REG_EVERY;
`ifdef SORT_NXW_INDEX_EN
    localparam int TW = $clog2(N);
`else
    localparam int TW = 0;
`endif
    // Each element is {key, tag}; the tag rides in the low TW bits and never takes part in the compare.
    localparam int EW = W + TW;

    // One network column: compare-exchange on even or odd pairs, swapping only when strictly out of order.
    function automatic logic [N*EW-1:0] oet_stage(input logic [N*EW-1:0] v, input logic odd, input logic desc);
        logic [N*EW-1:0] r;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        r = v;
        for (int j = 0; j < N - 1; j++) begin
            if (j[0] == odd) begin
                a = v[j*EW+TW +: W];
                b = v[(j+1)*EW+TW +: W];
                if (desc ? (a < b) : (a > b)) begin
                    r[j*EW +: EW]     = v[(j+1)*EW +: EW];
                    r[(j+1)*EW +: EW] = v[j*EW +: EW];
                end
            end
        end
        return r;
    endfunction

    logic [N*EW-1:0] in_elems;
    logic [N*EW-1:0] st_in   [N];
    logic [N*EW-1:0] st_out  [N];
    logic            st_desc [N];
    logic [N*EW-1:0] slot_q  [L];
    logic [N*EW-1:0] slot_d  [L];
    logic [L-1:0]    vld_q;
    logic [L-1:0]    vld_d;
    logic [L-1:0]    desc_q;
    logic [L-1:0]    desc_d;
    logic            advance;

    // Repack the input vector into key/tag elements, tagging each with its input position.
    always_comb begin
        in_elems = '0;
        for (int i = 0; i < N; i++) begin
            in_elems[i*EW+TW +: W] = in_data[i*W +: W];
`ifdef SORT_NXW_INDEX_EN
            in_elems[i*EW +: TW] = TW'(i);
`endif
        end
    end

    // Stage k reads the previous stage directly, or a slot register at every REG_EVERY boundary.
    for (genvar k = 0; k < N; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign st_in[k]   = in_elems;
            assign st_desc[k] = in_desc;
        end else if (k % REG_EVERY == 0) begin : g_reg
            assign st_in[k]   = slot_q[k/REG_EVERY-1];
            assign st_desc[k] = desc_q[k/REG_EVERY-1];
        end else begin : g_comb
            assign st_in[k]   = st_out[k-1];
            assign st_desc[k] = st_desc[k-1];
        end
        assign st_out[k] = oet_stage(st_in[k], 1'(k % 2), st_desc[k]);
    end

    // Slot s captures the last stage of its group; valid and desc shift alongside the data.
    for (genvar s = 0; s < L; s++) begin : g_slot
        localparam int LAST = ((s + 1) * REG_EVERY < N) ? (s + 1) * REG_EVERY - 1 : N - 1;
        assign slot_d[s] = st_out[LAST];
        if (s == 0) begin : g_first
            assign vld_d[s]  = in_valid && in_ready;
            assign desc_d[s] = in_desc;
        end else begin : g_next
            assign vld_d[s]  = vld_q[s-1];
            assign desc_d[s] = desc_q[s-1];
        end
    end

    // Whole pipe moves together: shift on advance, freeze otherwise; bubbles travel like data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            desc_q <= '0;
            for (int s = 0; s < L; s++) begin
                slot_q[s] <= '0;
            end
        end else if (advance) begin
            vld_q  <= vld_d;
            desc_q <= desc_d;
            for (int s = 0; s < L; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[L-1];
    assign out_desc  = desc_q[L-1];

    // Strip tags back off the last slot to form the output vector(s).
    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            out_data[i*W +: W] = slot_q[L-1][i*EW+TW +: W];
        end
    end

`ifdef SORT_NXW_INDEX_EN
    // Original positions of the sorted elements.
    always_comb begin
        out_index = '0;
        for (int i = 0; i < N; i++) begin
            out_index[i*TW +: TW] = slot_q[L-1][i*EW +: TW];
        end
    end
`endif

endmodule

// File: tb/tb_sort_nxw_oet_pipe.sv
// tb/tb_sort_nxw_oet_pipe.sv - directed self-checking bench for sort_nxw_oet_pipe
module tb_sort_nxw_oet_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic        in_valid, in_ready, in_desc, out_valid, out_ready, out_desc;
    logic [63:0] in_data, out_data;
    logic [23:0] out_index;

    logic       a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready, a_out_desc;
    logic [1:0] a_in_data, a_out_data, a_out_index;
    logic        b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready, b_out_desc;
    logic [59:0] b_in_data, b_out_data;
    logic [14:0] b_out_index;
    logic         c_in_valid, c_in_ready, c_in_desc, c_out_valid, c_out_ready, c_out_desc;
    logic [255:0] c_in_data, c_out_data;
    logic [63:0]  c_out_index;

    sort_nxw_oet_pipe #(.N(8), .W(8), .REG_EVERY(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_desc(out_desc)
`ifdef SORT_NXW_INDEX_EN
        , .out_index(out_index)
`endif
    );

    sort_nxw_oet_pipe #(.N(2), .W(1), .REG_EVERY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_desc(a_in_desc), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_desc(a_out_desc)
`ifdef SORT_NXW_INDEX_EN
        , .out_index(a_out_index)
`endif
    );

    sort_nxw_oet_pipe #(.N(5), .W(12), .REG_EVERY(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_desc(b_in_desc), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_desc(b_out_desc)
`ifdef SORT_NXW_INDEX_EN
        , .out_index(b_out_index)
`endif
    );

    sort_nxw_oet_pipe #(.N(16), .W(16), .REG_EVERY(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .in_desc(c_in_desc), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_desc(c_out_desc)
`ifdef SORT_NXW_INDEX_EN
        , .out_index(c_out_index)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic        desc;
        logic [23:0] idx;
    } exp_t;

    exp_t exp_q[$];

    // Reference: stable insertion sort of 8 bytes with their original positions.
    function automatic exp_t ref_sort8(input logic [63:0] v, input logic desc);
        logic [7:0] k [8];
        logic [2:0] ix [8];
        logic [7:0] tk;
        logic [2:0] ti;
        exp_t       e;
        for (int i = 0; i < 8; i++) begin
            k[i]  = v[i*8 +: 8];
            ix[i] = 3'(i);
        end
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (k[j-1] < k[j]) : (k[j-1] > k[j])) begin
                    tk = k[j-1]; k[j-1] = k[j]; k[j] = tk;
                    ti = ix[j-1]; ix[j-1] = ix[j]; ix[j] = ti;
                end else begin
                    break;
                end
            end
        end
        e.desc = desc;
        for (int i = 0; i < 8; i++) begin
            e.d[i*8 +: 8]   = k[i];
            e.idx[i*3 +: 3] = ix[i];
        end
        return e;
    endfunction

    task automatic test_reset();
        in_valid = 0; in_data = '0; in_desc = 0; out_ready = 1;
        a_in_valid = 0; a_in_data = '0; a_in_desc = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_desc = 0; b_out_ready = 1;
        c_in_valid = 0; c_in_data = '0; c_in_desc = 0; c_out_ready = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (out_desc !== 1'b0) begin bad++; $display("FAIL reset_out_desc got=%b want=0", out_desc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if ({a_out_valid, b_out_valid, c_out_valid} !== 3'b000) begin
            bad++; $display("FAIL reset_sweep_valid got=%b want=000", {a_out_valid, b_out_valid, c_out_valid});
        end
`ifdef SORT_NXW_INDEX_EN
        total++; if (out_index !== 24'h0) begin bad++; $display("FAIL reset_out_index got=%h want=0", out_index); end
`endif
    endtask

    task automatic directed_vector(input string name, input logic [63:0] v, input logic d,
                                   input logic [63:0] exp_d, input logic [23:0] exp_i);
        in_data = v; in_desc = d; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0; in_data = 64'hDEAD_BEEF_0BAD_F00D; in_desc = ~d;
        for (int i = 1; i < 4; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid cycle=%0d got=%b want=0", name, i, out_valid); end
            @(posedge clk); #1;
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_latency got=%b want=1", name, out_valid); end
        total++; if (out_data !== exp_d) begin bad++; $display("FAIL %s_data got=%h want=%h", name, out_data, exp_d); end
        total++; if (out_desc !== d) begin bad++; $display("FAIL %s_desc got=%b want=%b", name, out_desc, d); end
`ifdef SORT_NXW_INDEX_EN
        total++; if (out_index !== exp_i) begin bad++; $display("FAIL %s_index got=%h want=%h", name, out_index, exp_i); end
`else
        if (exp_i === 24'hx) $display("%s", name);
`endif
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_single_beat got=%b want=0", name, out_valid); end
    endtask

    task automatic test_ascending();
        directed_vector("asc",
            {8'd4, 8'd7, 8'd2, 8'd9, 8'd1, 8'd8, 8'd3, 8'd5}, 1'b0,
            {8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
            {3'd4, 3'd2, 3'd6, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3});
    endtask

    task automatic test_descending();
        directed_vector("desc",
            {8'hFF, 8'h00, 8'hFE, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h00}, 1'b1,
            {8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'hFF},
            {3'd6, 3'd0, 3'd4, 3'd3, 3'd2, 3'd5, 3'd7, 3'd1});
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   got = 0;
        exp_q.delete();
        out_ready = 1;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                in_valid = 1;
                in_desc  = c[0];
                for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = c[1] ? 8'($urandom_range(0, 3)) : 8'($urandom);
            end else begin
                in_valid = 0;
            end
            #1;
            total++; if (out_valid !== (c >= 4 && c < 20)) begin bad++; $display("FAIL b2b_valid cycle=%0d got=%b want=%b", c, out_valid, (c >= 4 && c < 20)); end
            if (out_valid && out_ready) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra cycle=%0d got=%h want=none", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_desc !== e.desc) begin
                        bad++; $display("FAIL b2b_data cycle=%0d got=%h/%b want=%h/%b", c, out_data, out_desc, e.d, e.desc);
                    end
`ifdef SORT_NXW_INDEX_EN
                    total++; if (out_index !== e.idx) begin bad++; $display("FAIL b2b_index cycle=%0d got=%h want=%h", c, out_index, e.idx); end
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_sort8(in_data, in_desc));
            @(posedge clk); #1;
        end
        total++; if (got != 16) begin bad++; $display("FAIL b2b_count got=%0d want=16", got); end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [63:0] cur, held;
        logic        cur_d, held_d;
        int          sent = 0, got = 0;
        bit          have = 0;
        exp_q.delete();
        held = '0; held_d = 0; cur = '0; cur_d = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 6 && c < 11);
            if (sent < 12) begin
                if (!have) begin
                    for (int k = 0; k < 8; k++) cur[k*8 +: 8] = 8'($urandom_range(0, 15));
                    cur_d = sent[0];
                    have  = 1;
                end
                in_valid = 1; in_data = cur; in_desc = cur_d;
            end else begin
                in_valid = 0;
            end
            #1;
            if (c == 6) begin
                held = out_data; held_d = out_desc;
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_full got=%b want=1", out_valid); end
            end
            if (c >= 6 && c < 11) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", c, in_ready); end
            end
            if (c >= 7 && c <= 11) begin
                total++; if (out_valid !== 1'b1 || out_data !== held || out_desc !== held_d) begin
                    bad++; $display("FAIL bp_hold cycle=%0d got=%b/%h want=1/%h", c, out_valid, out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra cycle=%0d got=%h want=none", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_desc !== e.desc) begin
                        bad++; $display("FAIL bp_data cycle=%0d got=%h/%b want=%h/%b", c, out_data, out_desc, e.d, e.desc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sort8(in_data, in_desc));
                sent++;
                have = 0;
            end
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        total++; if (got != 12 || exp_q.size() != 0) begin bad++; $display("FAIL bp_count got=%0d left=%0d want=12/0", got, exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_desc = 0;
            for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
        end
        in_valid = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL rstmid_data got=%h want=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale cycle=%0d got=%b want=0", c, out_valid); end
        end
    endtask

    task automatic test_sweep();
        logic [255:0] c_exp;
        logic [63:0]  c_exp_i;
        // N=2, W=1, L=2
        a_in_data = 2'b01; a_in_desc = 0; a_in_valid = 1;
        @(posedge clk); #1;
        a_in_valid = 0; a_in_data = 2'b11;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL sweep_a_early got=%b want=0", a_out_valid); end
        @(posedge clk); #1;
        total++; if (a_out_valid !== 1'b1 || a_out_data !== 2'b10) begin bad++; $display("FAIL sweep_a got=%b/%b want=1/10", a_out_valid, a_out_data); end
`ifdef SORT_NXW_INDEX_EN
        total++; if (a_out_index !== 2'b01) begin bad++; $display("FAIL sweep_a_index got=%b want=01", a_out_index); end
`endif
        // N=5, W=12, L=1
        b_in_data = {12'h123, 12'h800, 12'h000, 12'hFFF, 12'h123}; b_in_desc = 0; b_in_valid = 1;
        @(posedge clk); #1;
        b_in_valid = 0;
        total++; if (b_out_valid !== 1'b1 || b_out_data !== {12'hFFF, 12'h800, 12'h123, 12'h123, 12'h000}) begin
            bad++; $display("FAIL sweep_b got=%b/%h want=1/fff800123123000", b_out_valid, b_out_data);
        end
`ifdef SORT_NXW_INDEX_EN
        total++; if (b_out_index !== {3'd1, 3'd3, 3'd4, 3'd0, 3'd2}) begin bad++; $display("FAIL sweep_b_index got=%h want=%h", b_out_index, {3'd1, 3'd3, 3'd4, 3'd0, 3'd2}); end
`endif
        // N=16, W=16, L=6, fully reversed input
        for (int i = 0; i < 16; i++) begin
            c_in_data[i*16 +: 16] = 16'((15 - i) * 16'h1001);
            c_exp[i*16 +: 16]     = 16'(i * 16'h1001);
            c_exp_i[i*4 +: 4]     = 4'(15 - i);
        end
        c_in_desc = 0; c_in_valid = 1;
        @(posedge clk); #1;
        c_in_valid = 0;
        for (int i = 1; i < 6; i++) begin
            total++; if (c_out_valid !== 1'b0) begin bad++; $display("FAIL sweep_c_early cycle=%0d got=%b want=0", i, c_out_valid); end
            @(posedge clk); #1;
        end
        total++; if (c_out_valid !== 1'b1 || c_out_data !== c_exp) begin bad++; $display("FAIL sweep_c got=%b/%h want=1/%h", c_out_valid, c_out_data, c_exp); end
`ifdef SORT_NXW_INDEX_EN
        total++; if (c_out_index !== c_exp_i) begin bad++; $display("FAIL sweep_c_index got=%h want=%h", c_out_index, c_exp_i); end
`else
        if (c_exp_i === 64'hx) $display("sweep");
`endif
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
